// File: rtl/cache_bus_pkg.sv
// Shared encodings for the cache bus arbiter: FSM states, transaction owner and access size.
package cache_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_INST = 2'd1,
      OWN_DATA = 2'd2
   } owner_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// The i-side, d-side and bridge sram-like buses around the arbiter, bundled as one interface.
interface cache_bus_arbiter_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  inst_req;
   logic                  inst_wr;
   logic [1:0]            inst_size;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic [31:0]           inst_wdata;
   logic [31:0]           inst_rdata;
   logic                  inst_addr_ok;
   logic                  inst_data_ok;

   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [31:0]           data_wdata;
   logic [31:0]           data_rdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;

   logic                  mem_req;
   logic                  mem_wr;
   logic [1:0]            mem_size;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;
   logic                  mem_addr_ok;
   logic                  mem_data_ok;

   // slave: the arbiter's view (serves the caches, drives the bridge)
   modport slave (
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      output inst_rdata, inst_addr_ok, inst_data_ok,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_rdata, data_addr_ok, data_data_ok,
      output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      input  mem_rdata, mem_addr_ok, mem_data_ok
   );

   // master: the caches plus the bridge, as seen from outside the arbiter
   modport master (
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      input  inst_rdata, inst_addr_ok, inst_data_ok,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_rdata, data_addr_ok, data_data_ok,
      input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
      output mem_rdata, mem_addr_ok, mem_data_ok
   );

endinterface

// File: rtl/cache_bus_arbiter_arb_pick.sv
// Combinational requester pick: fixed data priority (ARB_MODE 0) or alternate on tie (ARB_MODE 1).
module arb_pick #(
   parameter int ARB_MODE = 0
) (
   input  logic inst_req,
   input  logic data_req,
   input  logic rr_last_data,
   output logic grant_inst,
   output logic grant_data,
   output logic valid
);

   always_comb begin
      valid = inst_req | data_req;
      if (inst_req & data_req)
         grant_data = (ARB_MODE == 0) ? 1'b1 : ~rr_last_data;
      else
         grant_data = data_req;
      grant_inst = valid & ~grant_data;
   end

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one sram-like bridge port between i_cache and d_cache, one transaction in flight,
// grant locked from issue until data_ok.
module cache_bus_arbiter
   import cache_bus_pkg::*;
#(
   parameter int ARB_MODE   = 0,
   parameter int ADDR_WIDTH = 32
) (
   input logic               clk,
   input logic               rst,
   cache_bus_arbiter_if.slave bus
);

   state_t                state;
   owner_t                owner;
   owner_t                rr_last;
   logic                  grant_inst;
   logic                  grant_data;
   logic                  pick_valid;
   logic                  sel_inst;
   logic                  sel_data;
   logic                  req_out;
   logic                  fire_addr;
   logic                  done;
   logic [ADDR_WIDTH-1:0] addr_mux;

   arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
      .inst_req     (bus.inst_req),
      .data_req     (bus.data_req),
      .rr_last_data (rr_last == OWN_DATA),
      .grant_inst   (grant_inst),
      .grant_data   (grant_data),
      .valid        (pick_valid)
   );

   // The pick only steers the bus in IDLE; afterwards the latched owner does.
   always_comb begin
      sel_inst = 1'b0;
      sel_data = 1'b0;
      req_out  = 1'b0;
      if (!rst) begin
         if (state == IDLE) begin
            sel_inst = grant_inst;
            sel_data = grant_data;
            req_out  = pick_valid;
         end else begin
            sel_inst = (owner == OWN_INST);
            sel_data = (owner == OWN_DATA);
            if (state == ADDR)
               req_out = (sel_inst & bus.inst_req) | (sel_data & bus.data_req);
         end
      end
   end

   assign fire_addr = req_out & bus.mem_addr_ok;
   // data_ok completes only after (or together with) an accepted address
   assign done      = bus.mem_data_ok & (sel_inst | sel_data) & (fire_addr | (state == DATA));

   assign addr_mux      = sel_inst ? bus.inst_addr : (sel_data ? bus.data_addr : '0);
   assign bus.mem_addr  = addr_mux;
   assign bus.mem_req   = req_out;
   assign bus.mem_wr    = (sel_inst & bus.inst_wr) | (sel_data & bus.data_wr);
   assign bus.mem_size  = sel_inst ? bus.inst_size  : (sel_data ? bus.data_size  : 2'd0);
   assign bus.mem_wdata = sel_inst ? bus.inst_wdata : (sel_data ? bus.data_wdata : 32'd0);

   assign bus.inst_addr_ok = fire_addr & sel_inst;
   assign bus.data_addr_ok = fire_addr & sel_data;
   assign bus.inst_data_ok = done & sel_inst;
   assign bus.data_data_ok = done & sel_data;
   assign bus.inst_rdata   = bus.mem_rdata;
   assign bus.data_rdata   = bus.mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= OWN_NONE;
         rr_last <= OWN_INST;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  if (done) begin
                     rr_last <= grant_data ? OWN_DATA : OWN_INST;
                  end else begin
                     state <= fire_addr ? DATA : ADDR;
                     owner <= grant_data ? OWN_DATA : OWN_INST;
                  end
               end
            end
            ADDR: begin
               if (fire_addr) begin
                  if (done) begin
                     state   <= IDLE;
                     owner   <= OWN_NONE;
                     rr_last <= owner;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (done) begin
                  state   <= IDLE;
                  owner   <= OWN_NONE;
                  rr_last <= owner;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
